// File: rtl/sound_mixer_att.sv
// rtl/sound_mixer_att.sv - serial N-channel mixer with runtime MUL/2^SHIFT gains and saturation
// Optional: define SOUND_MIXER_CLIP_COUNT_EN to build the CLIP_CNT saturation counter.
module sound_mixer_att #(
    parameter int CHANNELS    = 4,
    parameter int IN_WIDTH    = 10,
    parameter int OUT_WIDTH   = 16,
    parameter int MUL_WIDTH   = 4,
    parameter int SHIFT_WIDTH = 3,
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          START,
    input  logic [CHANNELS*IN_WIDTH-1:0]  IN_DATA,
    input  logic                          GAIN_WE,
    input  logic [CH_W-1:0]               GAIN_CH,
    input  logic [MUL_WIDTH-1:0]          GAIN_MUL,
    input  logic [SHIFT_WIDTH-1:0]        GAIN_SHIFT,
    output logic                          BUSY,
    output logic [OUT_WIDTH-1:0]          OUT_DATA,
    output logic                          OUT_VALID,
    output logic [7:0]                    CLIP_CNT
);
    localparam int PROD_W = IN_WIDTH + MUL_WIDTH + 1;
    localparam int ACC_W  = PROD_W + $clog2(CHANNELS);
    localparam int CMP_W  = ((ACC_W > OUT_WIDTH) ? ACC_W : OUT_WIDTH) + 1;
    localparam logic signed [CMP_W-1:0] MAX_V = CMP_W'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
    localparam logic signed [CMP_W-1:0] MIN_V = ~MAX_V;

    typedef enum logic [1:0] {IDLE, ACC, SAT} state_t;
    state_t state, state_next;

    logic [MUL_WIDTH-1:0]          pend_mul   [CHANNELS];
    logic [SHIFT_WIDTH-1:0]        pend_shift [CHANNELS];
    logic [MUL_WIDTH-1:0]          act_mul    [CHANNELS];
    logic [SHIFT_WIDTH-1:0]        act_shift  [CHANNELS];
    logic signed [IN_WIDTH-1:0]    snap       [CHANNELS];
    logic signed [ACC_W-1:0]       acc;
    logic [CH_W-1:0]               ch;

    logic                          accept;
    logic                          last;
    logic                          gain_hit;
    logic signed [IN_WIDTH-1:0]    sample;
    logic signed [MUL_WIDTH:0]     mul_s;
    logic signed [PROD_W-1:0]      product;
    logic signed [PROD_W-1:0]      term;
    logic signed [ACC_W-1:0]       sum;
    logic signed [CMP_W-1:0]       sum_ext;
    logic                          clip_hi;
    logic                          clip_lo;
    logic [OUT_WIDTH-1:0]          sat_val;

    assign accept   = (state == IDLE) && START;
    assign last     = (ch == CH_W'(CHANNELS - 1));
    assign gain_hit = GAIN_WE && ({{(32-CH_W){1'b0}}, GAIN_CH} < 32'(CHANNELS));
    assign BUSY     = (state != IDLE);

    // One channel term per cycle; the multiplier is zero-extended so it stays non-negative.
    always_comb begin
        sample  = snap[ch];
        mul_s   = signed'({1'b0, act_mul[ch]});
        product = PROD_W'(sample) * PROD_W'(mul_s);
        term    = product >>> act_shift[ch];
        sum     = acc + ACC_W'(term);
        sum_ext = CMP_W'(sum);
        clip_hi = (sum_ext > MAX_V);
        clip_lo = (sum_ext < MIN_V);
        if (clip_hi)
            sat_val = MAX_V[OUT_WIDTH-1:0];
        else if (clip_lo)
            sat_val = MIN_V[OUT_WIDTH-1:0];
        else
            sat_val = sum_ext[OUT_WIDTH-1:0];
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (START) state_next = ACC;
            ACC:     if (last) state_next = SAT;
            SAT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The final sum is clamped as the last term lands, so OUT_VALID coincides with the SAT cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            acc       <= '0;
            ch        <= '0;
            OUT_DATA  <= '0;
            OUT_VALID <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) begin
                pend_mul[k]   <= MUL_WIDTH'(1);
                pend_shift[k] <= '0;
                act_mul[k]    <= MUL_WIDTH'(1);
                act_shift[k]  <= '0;
                snap[k]       <= '0;
            end
        end else begin
            state     <= state_next;
            OUT_VALID <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) begin
                if (gain_hit && (GAIN_CH == CH_W'(k))) begin
                    pend_mul[k]   <= GAIN_MUL;
                    pend_shift[k] <= GAIN_SHIFT;
                end
            end
            if (accept) begin
                acc <= '0;
                ch  <= '0;
                // A write landing with START bypasses the pending stage into this frame.
                for (int k = 0; k < CHANNELS; k++) begin
                    snap[k] <= IN_DATA[k*IN_WIDTH +: IN_WIDTH];
                    if (gain_hit && (GAIN_CH == CH_W'(k))) begin
                        act_mul[k]   <= GAIN_MUL;
                        act_shift[k] <= GAIN_SHIFT;
                    end else begin
                        act_mul[k]   <= pend_mul[k];
                        act_shift[k] <= pend_shift[k];
                    end
                end
            end else if (state == ACC) begin
                acc <= sum;
                if (last) begin
                    OUT_DATA  <= sat_val;
                    OUT_VALID <= 1'b1;
                end else begin
                    ch <= ch + CH_W'(1);
                end
            end
        end
    end

`ifdef SOUND_MIXER_CLIP_COUNT_EN
    logic [7:0] clip_cnt;

    always_ff @(posedge CLK) begin
        if (RESET)
            clip_cnt <= '0;
        else if ((state == ACC) && last && (clip_hi || clip_lo) && (clip_cnt != 8'hFF))
            clip_cnt <= clip_cnt + 8'd1;
    end

    assign CLIP_CNT = clip_cnt;
`else
    assign CLIP_CNT = 8'd0;
`endif

endmodule
